// File: rtl/bin2bcd_if.sv
// Operand/result handshake bundle for the sequential binary-to-BCD converter.
// The converter sits on the slave side; the producer/consumer drives the master side.
interface bin2bcd_if #(
  parameter int N = 8,
  parameter int D = 3
);
  logic [N-1:0]   din;
  logic           in_valid;
  logic           in_ready;
  logic [4*D-1:0] dout;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  modport master (
    output din, in_valid, out_ready,
    input  in_ready, dout, out_valid, busy
  );

  modport slave (
    input  din, in_valid, out_ready,
    output in_ready, dout, out_valid, busy
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Double-dabble converter: one operand at a time, N shift cycles per conversion,
// packed BCD result held until the consumer takes it.
module bin2bcd_seq #(
  parameter int N = 8,
  parameter int D = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  bin2bcd_if.slave    bus,
  output logic [1:0]  dbg_state
);
  localparam int CW = $clog2(N + 1);

  // Handshake rule for both ports: a transfer happens on a rising clk edge
  // where valid and ready are both high; valid and data hold until then.
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     bin_q, bin_d;
  logic [4*D-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4*D-1:0]   adj;
  logic [4*D+N-1:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    adj     = '0;
    // Digits >= 5 would become >= 10 after doubling, so pre-correct them by 3.
    for (int k = 0; k < D; k++) begin
      adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
    end
    sh = {adj, bin_q} << 1;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          bin_d   = bus.din;
          bcd_d   = '0;
          cnt_d   = CW'(N);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = sh[N +: 4*D];
        bin_d = sh[N-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.dout      = bcd_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: handshake timing, backpressure, reset and
// a model-checked sweep, with the excess-3 view of each emitted digit.
module tb_bin2bcd_seq;
  localparam int N = 8;
  localparam int D = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         tests_run;
  int         tests_failed;

  bin2bcd_if #(.N(N), .D(D)) bus ();

  bin2bcd_seq #(.N(N), .D(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  if (!(10**D > 2**N - 1)) begin : g_bad_d
    initial $fatal(1, "FAIL d_constraint: 10^D must exceed 2^N-1");
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_conv(input logic [N-1:0] v, input logic [4*D-1:0] exp, input string name);
    int cyc;
    int bad;
    @(negedge clk);
    bus.din       = v;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    tests_run++;
    if (cyc !== N) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cyc, N);
    end
    tests_run++;
    if (bus.dout !== exp) begin
      tests_failed++;
      $display("FAIL %s_dout: got %h, expected %h", name, bus.dout, exp);
    end
    bad = 0;
    for (int k = 0; k < D; k++) if (bus.dout[4*k +: 4] > 4'd9) bad++;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL %s_digit_range: %0d digits above 9 in %h", name, bad, bus.dout);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_handoff: in_ready=%b out_valid=%b, expected 1/0", name, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.din       = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #23;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.dout !== '0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b dout=%h state=%0d, expected 1 0 0 000 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.dout, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_conv(8'd0,   12'h000, "basic_0");
    do_conv(8'd99,  12'h099, "basic_99");
    do_conv(8'd128, 12'h128, "basic_128");
    do_conv(8'd255, 12'h255, "basic_255");
  endtask

  task automatic test_backpressure();
    int cyc;
    @(negedge clk);
    bus.din       = 8'd200;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.dout !== 12'h200 || bus.in_ready !== 1'b0 || dbg_state !== 2'd2) begin
        tests_failed++;
        $display("FAIL backpressure_hold%0d: out_valid=%b dout=%h in_ready=%b state=%0d, expected 1 200 0 2",
                 i, bus.out_valid, bus.dout, bus.in_ready, dbg_state);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, expected 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int acc[2];
    int n_acc;
    int outs;
    int c;
    logic [11:0] exp_q[$];
    logic [11:0] exp;
    exp_q = {12'h037, 12'h064};
    n_acc = 0;
    outs  = 0;
    c     = 0;
    @(negedge clk);
    bus.din       = 8'd37;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (outs < 2 && c < 60) begin
      if (c > 0) @(negedge clk);
      if (n_acc == 1) bus.din = 8'd64;
      if (bus.in_ready && n_acc < 2) begin
        acc[n_acc] = c;
        n_acc++;
      end
      if (bus.out_valid) begin
        exp = exp_q.pop_front();
        tests_run++;
        if (bus.dout !== exp) begin
          tests_failed++;
          $display("FAIL b2b_dout%0d: got %h, expected %h", outs, bus.dout, exp);
        end
        outs++;
      end
      @(posedge clk);
      c++;
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (n_acc !== 2 || acc[1] - acc[0] !== 10) begin
      tests_failed++;
      $display("FAIL b2b_period: accepts=%0d spacing=%0d, expected 2 accepts 10 apart", n_acc, acc[1] - acc[0]);
    end
  endtask

  task automatic test_ignored_input();
    @(negedge clk);
    bus.din       = 8'd123;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.din      = 8'($urandom_range(0, 255));
      bus.in_valid = 1'($urandom_range(0, 1));
      tests_run++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL ignored_shift%0d: busy=%b in_ready=%b, expected 1/0", i, bus.busy, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.dout !== 12'h123) begin
      tests_failed++;
      $display("FAIL ignored_result: out_valid=%b dout=%h, expected 1 123", bus.out_valid, bus.dout);
    end
    @(posedge clk);
    #1;
    do_conv(8'd77, 12'h077, "ignored_next");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.din       = 8'd250;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.dout !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: out_valid=%b busy=%b in_ready=%b dout=%h, expected 0 0 1 000",
               bus.out_valid, bus.busy, bus.in_ready, bus.dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_conv(8'd5, 12'h005, "after_reset");
  endtask

  task automatic test_random_sweep();
    logic [N-1:0]   v;
    logic [4*D-1:0] exp;
    logic [4:0]     xs3_exp;
    logic [4:0]     xs3_act;
    int             tmp;
    for (int i = 0; i < 20; i++) begin
      v   = N'($urandom_range(0, 2**N - 1));
      exp = '0;
      tmp = int'(v);
      for (int k = 0; k < D; k++) begin
        exp[4*k +: 4] = 4'(tmp % 10);
        tmp = tmp / 10;
      end
      do_conv(v, exp, "sweep");
      for (int k = 0; k < D; k++) begin
        xs3_exp = 5'(((int'(v) / (10**k)) % 10) + 3);
        xs3_act = {1'b0, bus.dout[4*k +: 4]} + 5'd3;
        tests_run++;
        if (xs3_act !== xs3_exp) begin
          tests_failed++;
          $display("FAIL sweep_xs3 din=%0d digit%0d: got %0d, expected %0d", v, k, xs3_act, xs3_exp);
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_ignored_input();
    test_async_reset();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
